// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and receiver state encoding.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer.
interface uart_rx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ack;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    modport master (output data, valid, frame_err, overrun, busy, input ack);
    modport slave  (input data, valid, frame_err, overrun, busy, output ack);
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
module uart_sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversamples rx, presents each byte on a valid/ack handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rx,
    uart_rx_if.master bus
);
    // state | meaning
    // IDLE  | line idle, waiting for a low rx_s
    // START | timing to the start-bit midpoint to confirm it
    // DATA  | sampling data bits at their midpoints, LSB first
    // STOP  | sampling the stop bit; publishes byte or flags framing error
    // BREAK | stop bit was low; wait for the line to return high

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int BW       = $clog2(DATA_BITS);

    rx_state_t            state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [BW-1:0]        bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 valid_q, valid_n;
    logic                 frame_err_q, frame_err_n;
    logic                 overrun_q, overrun_n;
    logic                 rx_s;
    logic                 sample;

    uart_sync2 u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_idx     <= bit_idx_n;
            shift       <= shift_n;
            data_q      <= data_n;
            valid_q     <= valid_n;
            frame_err_q <= frame_err_n;
            overrun_q   <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        data_n      = data_q;
        valid_n     = valid_q & ~bus.ack;
        frame_err_n = frame_err_q;
        overrun_n   = overrun_q;
        sample      = (state == START && cnt == CW'(HALF_BIT - 1)) ||
                      ((state == DATA || state == STOP) && cnt == CW'(CLKS_PER_BIT - 1));

        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (sample) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                if (sample) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    bit_idx_n        = bit_idx + BW'(1);
                    if (bit_idx == BW'(DATA_BITS - 1))
                        state_n = STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                if (sample) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        // An ack in this same cycle consumes the old byte, so no overrun.
                        data_n      = shift;
                        valid_n     = 1'b1;
                        frame_err_n = 1'b0;
                        overrun_n   = overrun_q | (valid_q & ~bus.ack);
                        state_n     = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            BREAK: begin
                if (rx_s)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, LSB first; the receive-side counterpart of the team's 8N1 transmitter.
- Runs on the system clock and oversamples the asynchronous serial line.
- Recovers each byte and presents it on a level-valid / ack handshake to the consuming logic (command parser, loopback checker).
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 16: system clocks per serial bit. Must be even and ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2: derived local constant, not overridable; the start-bit midpoint offset.

Ports:
- clock      input   1  system clock
- reset_n    input   1  reset, synchronous, active-low
- rx         input   1  asynchronous serial line, idle high
- data       output  8  last correctly received byte
- valid      output  1  level; high while data is unconsumed
- ack        input   1  consumer strobe; clears valid
- frame_err  output  1  stop bit sampled low on the most recent frame
- overrun    output  1  sticky; a byte completed while valid was still high and not acked
- busy       output  1  high in every state except IDLE

Behaviour:
- Reset (reset_n low at a clock edge, including mid-frame):
  - state goes to IDLE; all counters go to 0.
  - data=0, valid=0, frame_err=0, overrun=0, busy=0.
  - Both synchronizer flops go to 1.
- Input synchronization: rx passes through a 2-FF synchronizer to give rx_s. Only rx_s is used internally.
- Counting: cnt increments every cycle in START, DATA and STOP. A "sample event" occurs when cnt hits the terminal value; at that edge cnt returns to 0.
  - START terminal value: HALF_BIT-1.
  - DATA and STOP terminal value: CLKS_PER_BIT-1.
- States:
  - IDLE: when rx_s==0, go to START with cnt=0.
  - START: at the sample event, rx_s==0 → DATA with bit_idx=0. rx_s==1 → IDLE (glitch rejected; no flags change).
  - DATA: at each sample event, shift[bit_idx]<=rx_s and increment bit_idx. After bit_idx==7 is sampled, go to STOP.
  - STOP, sample rx_s==1: data<=shift, valid<=1, frame_err<=0. overrun<=overrun|(valid&~ack). Next state IDLE, so a back-to-back start bit is caught half a bit early.
  - STOP, sample rx_s==0: frame_err<=1. data and valid are unchanged. Next state BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. A held-low line never retriggers START.
- Handshake:
  - ack with valid high clears valid on the next edge.
  - ack with valid low has no effect.
  - ack in the same cycle as a STOP success: valid stays 1, holding the new byte, and overrun is not set.
- Timing: define edge 1 as the first clock edge that samples rx low at a frame start. Then:
  - valid is visible after edge 3+HALF_BIT+9*CLKS_PER_BIT (edge 155 for 16).
  - frame_err is visible after the same edge.
- overrun clears only on reset. frame_err is updated on every completed stop sample.

Decomposition:
- uart_pkg holds the rx state enum (IDLE, START, DATA, STOP, BREAK) and DATA_BITS=8, shared with the transmitter.
- One sub-module: uart_sync2, a 2-FF synchronizer with reset value 1, reusable for other asynchronous inputs.

Test Plan:
- Reset, then send 0xA5 with CLKS_PER_BIT=16 → valid rises after edge 155, data=0xA5, frame_err=0, busy low after STOP.
- Low glitch of 4 cycles on rx in IDLE → START aborts at the midpoint; valid, data and frame_err unchanged; busy returns to 0.
- Frame 0x3C with stop bit low, then line held low for 40 bits, then high → frame_err=1, valid=0, no retrigger while low; next good frame 0x81 gives data=0x81, frame_err=0.
- Back-to-back frames 0x01, 0x02 with no ack → second completion sets overrun=1, data=0x02. Repeat with ack pulsed at the second completion edge → overrun stays 0.
- reset_n low mid-DATA of frame 0xFF, released, then send 0x5A → all outputs 0 during reset; 0x5A received cleanly.
- Loopback from the team transmitter with CLKS_PER_BIT=4, sending 0x00, 0xFF, 0x55 → each byte matches, with one valid per frame.
